inv_sub_bytes_seq: RTL and testbench
====================================

Name: inv_sub_bytes_seq

Overview:
- Sequential InvSubBytes engine for the AES decryption datapath; the inverse of the forward SubBytes stage.
- Accepts a 128-bit state in the same byte order produced by the plaintext-to-state mapping.
- Substitutes every byte through the AES inverse S-box, BYTES_PER_CYCLE bytes per clock, and returns the 128-bit result.
- Uses a valid/ready handshake on both sides.

Parameters:
- BYTES_PER_CYCLE, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16; any other value is a elaboration error (assertion).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state
- state_in  input  128  byte i = state_in[127-8i -: 8], i=0..15; byte i maps to matrix row i%4, column i/4
- out_valid  output  1  state_out is valid
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  inverse-substituted state, same byte order as state_in
- busy  output  1  high while in state BUSY

Behaviour:
- Constants: N = 16/BYTES_PER_CYCLE chunks; chunk k covers bytes k*BPC .. k*BPC+BPC-1.
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, state_out=128'h0, chunk counter=0.
- IDLE: in_ready=1. On in_valid&&in_ready, register state_in into the work register, clear the counter, and go to BUSY.
- BUSY: in_ready=0, busy=1.
  - Each cycle, replace chunk[counter] of the work register with InvSbox of each byte, then increment the counter.
  - After chunk N-1 is processed, go to DONE.
- DONE: out_valid=1 and state_out = work register, both held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE next cycle (out_valid=0, in_ready=1).
- Latency: handshake at cycle T gives out_valid at T+N+1. BPC=16 → 2 cycles; BPC=1 → 17 cycles.
- Throughput: one state per N+2 cycles when out_ready is held high. No overlap of input and output handshakes.
- in_valid outside IDLE is ignored; no buffering, and the upstream source must hold its data.
- out_ready outside DONE is ignored.
- state_out holds its last value after out_valid drops. It changes only when entering DONE.
- rst asserted in any state (including mid-BUSY or DONE with out_ready low): next cycle all outputs take reset values. Any in-flight state is discarded and no out_valid pulse occurs.
- Inverse S-box is a 256-entry combinational function per lane, with BPC parallel lanes.
- No state on the input side of the lanes other than the work register.

Optional Feature:
- Macro: INV_SUB_BYTES_ROUNDTRIP_CHECK_EN.
- Defined:
  - Adds output port check_err (1 bit) and a forward S-box per lane.
  - In BUSY, each lane checks Sbox(InvSbox(b)) == b for every byte processed.
  - Any mismatch sets sticky check_err, which stays set until rst. Reset value is 0.
  - No latency change.
- Undefined: the check_err port and forward S-boxes are absent; behaviour is otherwise identical.

Test Plan:
- BPC=4, state_in=128'h6363..63 (all bytes 0x63), out_ready=1 → state_out=128'h0 at handshake+5 cycles, out_valid high exactly 1 cycle.
- BPC=4, state_in=128'h0 → state_out=128'h5252..52. Then state_in=128'hFFFF..FF → 128'h7D7D..7D.
- Ordering check, BPC=1, state_in=128'h7C01_6363..63 → state_out=128'h0109_0000..00 at handshake+17 cycles; byte 0 = 0x01, byte 1 = 0x09.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and state_out stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-BUSY (BPC=1, rst at handshake+5) → next cycle out_valid=0, in_ready=1, state_out=0; no out_valid pulse afterward.
- Round trip: for all 256 values v, state_in = 16 copies of Sbox(v) → every output byte = v. With INV_SUB_BYTES_ROUNDTRIP_CHECK_EN defined, check_err remains 0 throughout.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: BYTES_PER_CYCLE inverse S-box lanes walk a 128-bit state chunk by chunk.
// Optional macro INV_SUB_BYTES_ROUNDTRIP_CHECK_EN adds forward S-boxes and a sticky check_err output.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef INV_SUB_BYTES_ROUNDTRIP_CHECK_EN
  ,
  output logic         check_err
`endif
);

  localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Element 0 is the leftmost byte, so the table reads in natural S-box order.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0][7:0]  work_q, work_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [127:0]      state_out_q;
  logic [7:0]        lane_in  [BYTES_PER_CYCLE];
  logic [7:0]        lane_out [BYTES_PER_CYCLE];

  // Byte i of the state lives at packed index 15-i of the work register.
  function automatic logic [3:0] byte_pos(input logic [CNT_W-1:0] c, input int lane);
    return 4'(15 - (int'(c) * BYTES_PER_CYCLE + lane));
  endfunction

  always_comb begin
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      lane_in[l] = work_q[byte_pos(cnt_q, l)];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    assign lane_out[g] = INV_SBOX[lane_in[g]];
  end

  always_comb begin
    work_d = work_q;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      work_d[byte_pos(cnt_q, l)] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
    unique case (state_q)
      IDLE:    if (in_valid)          state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // state_out is a separate register so it survives the next accepted state.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q      <= '0;
      cnt_q       <= '0;
      state_out_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= state_in;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          work_q <= work_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= '0;
            state_out_q <= work_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_out = state_out_q;

`ifdef INV_SUB_BYTES_ROUNDTRIP_CHECK_EN
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [BYTES_PER_CYCLE-1:0] lane_bad;
  logic                       check_err_q;

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_check
    assign lane_bad[g] = (SBOX[lane_out[g]] != lane_in[g]);
  end

  // Sticky until reset; only bytes actually processed in BUSY are judged.
  always_ff @(posedge clk) begin
    if (rst) check_err_q <= 1'b0;
    else if (state_q == BUSY && |lane_bad) check_err_q <= 1'b1;
  end

  assign check_err = check_err_q;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: instance 0 uses BYTES_PER_CYCLE=4, instance 1 uses BYTES_PER_CYCLE=1.
module tb_inv_sub_bytes_seq;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk;
  logic [1:0]   rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] state_in  [2];
  logic [127:0] state_out [2];
`ifdef INV_SUB_BYTES_ROUNDTRIP_CHECK_EN
  logic [1:0]   check_err;
`endif

  int checks;
  int failures;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .state_in  (state_in[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .state_out (state_out[0]),
    .busy      (busy[0])
`ifdef INV_SUB_BYTES_ROUNDTRIP_CHECK_EN
    ,
    .check_err (check_err[0])
`endif
  );

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .state_in  (state_in[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .state_out (state_out[1]),
    .busy      (busy[1])
`ifdef INV_SUB_BYTES_ROUNDTRIP_CHECK_EN
    ,
    .check_err (check_err[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Push one state through instance d with out_ready held high.
  task automatic applyStimulus(input int d, input logic [127:0] din, input logic [127:0] exp, input string tag);
    int n;
    int cnt;
    n = (d == 0) ? 4 : 16;
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    state_in[d]  = din;
    tick();
    in_valid[d] = 1'b0;
    checkOutput({tag, "_busy"}, 128'(busy[d]), 128'd1);
    cnt = 0;
    while (!out_valid[d] && cnt < 64) begin
      tick();
      cnt++;
    end
    checkOutput({tag, "_latency"}, 128'(cnt), 128'(n));
    checkOutput({tag, "_data"}, state_out[d], exp);
    tick();
    checkOutput({tag, "_valid_drop"}, {126'd0, out_valid[d], in_ready[d]}, 128'd1);
    checkOutput({tag, "_held"}, state_out[d], exp);
  endtask

  initial begin
    int cnt;
    int pulses;
    logic [127:0] held;
    checks    = 0;
    failures  = 0;
    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    state_in[0] = '0;
    state_in[1] = '0;
    tick();
    tick();
    rst = 2'b00;

    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_flags", {125'd0, in_ready[d], out_valid[d], busy[d]}, 128'd4);
      checkOutput("reset_state_out", state_out[d], 128'd0);
    end

    applyStimulus(0, {16{8'h63}}, 128'd0, "all63");
    applyStimulus(0, 128'd0, {16{8'h52}}, "all00");
    applyStimulus(0, {16{8'hff}}, {16{8'h7d}}, "allff");
    applyStimulus(1, 128'h7c016363636363636363636363636363,
                  128'h01090000000000000000000000000000, "order_bpc1");

    // Backpressure: hold out_ready low in DONE while a second request is offered.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    state_in[0]  = 128'd0;
    tick();
    state_in[0] = {16{8'hff}};
    cnt = 0;
    while (!out_valid[0] && cnt < 64) begin
      tick();
      cnt++;
    end
    checkOutput("bp_latency", 128'(cnt), 128'd4);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", {126'd0, out_valid[0], in_ready[0]}, 128'd2);
      checkOutput("bp_data", state_out[0], {16{8'h52}});
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    checkOutput("bp_release", {125'd0, in_ready[0], out_valid[0], busy[0]}, 128'd4);
    checkOutput("bp_release_data", state_out[0], {16{8'h52}});

    // Reset in the middle of a BPC=1 pass.
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    state_in[1]  = {16{8'h63}};
    tick();
    in_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst_busy", 128'(busy[1]), 128'd1);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    checkOutput("midrst_flags", {125'd0, in_ready[1], out_valid[1], busy[1]}, 128'd4);
    checkOutput("midrst_state_out", state_out[1], 128'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid[1]) pulses++;
    end
    checkOutput("midrst_no_pulse", 128'(pulses), 128'd0);
    applyStimulus(1, {16{8'h00}}, {16{8'h52}}, "after_rst_bpc1");

    // Round trip over every byte value.
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      b = 8'(v);
      applyStimulus(0, {16{SBOX[b]}}, {16{b}}, $sformatf("rt_%02h", b));
    end

`ifdef INV_SUB_BYTES_ROUNDTRIP_CHECK_EN
    checkOutput("check_err4", 128'(check_err[0]), 128'd0);
    checkOutput("check_err1", 128'(check_err[1]), 128'd0);
`endif

    held = state_out[0];
    $display("[TB] last state_out=%h", held);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
